// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multi-cycle RV32I-subset datapath.
// Sequences fetch/decode/execute/memory/writeback over a shared ALU and a
// unified memory, counts retired instructions and halts on illegal encodings.
module multicycle_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [2:0]           alu_ctrl,
  output logic [1:0]           result_src,
  output logic [1:0]           imm_src,
  output logic                 trap,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t               state_reg;
  state_t               state_next;
  logic                 trap_reg;
  logic [CNT_WIDTH-1:0] instret_reg;
  logic                 retire;

  logic                 funct_ok;
  logic                 is_lw;
  logic                 is_sw;
  logic                 is_r;
  logic                 is_i;
  logic                 is_br;
  logic [2:0]           alu_funct;

  // Instruction classification; op/funct fields are stable from DECODE on.
  always_comb begin
    funct_ok = (funct3 == 3'b000) || (funct3 == 3'b111) ||
               (funct3 == 3'b110) || (funct3 == 3'b010);
    is_lw    = (op == OP_LOAD)  && (funct3 == 3'b010);
    is_sw    = (op == OP_STORE) && (funct3 == 3'b010);
    is_r     = (op == OP_RTYPE) && funct_ok;
    is_i     = (op == OP_ITYPE) && funct_ok;
    is_br    = (op == OP_BRANCH) && (funct3[2:1] == 2'b00);
  end

  // ALU operation from funct3; funct7_5 only selects sub for register-register ops.
  always_comb begin
    alu_funct = ALU_ADD;
    case (funct3)
      3'b000:  alu_funct = (state_reg == S_EXEC_R && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_funct = ALU_AND;
      3'b110:  alu_funct = ALU_OR;
      3'b010:  alu_funct = ALU_SLT;
      default: alu_funct = ALU_ADD;
    endcase
  end

  // Next-state and control outputs; everything forced low while reset is held.
  always_comb begin
    state_next = state_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_ctrl   = ALU_ADD;
    result_src = 2'b00;
    imm_src    = 2'b00;
    retire     = 1'b0;
    if (rst) begin
      case (state_reg)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            state_next = S_DECODE;
          end
        end
        S_DECODE: begin
          // Branch target computed early so BRANCH only has to compare.
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = 2'b10;
          if (is_lw || is_sw) state_next = S_MEMADR;
          else if (is_r)      state_next = S_EXEC_R;
          else if (is_i)      state_next = S_EXEC_I;
          else if (is_br)     state_next = S_BRANCH;
          else                state_next = S_TRAP;
        end
        S_MEMADR: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b01;
          imm_src    = (op == OP_STORE) ? 2'b01 : 2'b00;
          state_next = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          if (mem_ready) state_next = S_MEMWB;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          adr_src = 1'b1;
          if (mem_ready) begin
            retire     = 1'b1;
            state_next = S_FETCH;
          end
        end
        S_EXEC_R: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b00;
          alu_ctrl   = alu_funct;
          state_next = S_ALUWB;
        end
        S_EXEC_I: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b01;
          imm_src    = 2'b00;
          alu_ctrl   = alu_funct;
          state_next = S_ALUWB;
        end
        S_ALUWB: begin
          result_src = 2'b00;
          reg_write  = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_BRANCH: begin
          // funct3[0] distinguishes bne from beq, inverting the taken sense.
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b00;
          alu_ctrl   = ALU_SUB;
          result_src = 2'b00;
          pc_write   = zero ^ funct3[0];
          retire     = 1'b1;
          state_next = S_FETCH;
        end
        S_TRAP: begin
          state_next = S_TRAP;
        end
        default: begin
          state_next = S_TRAP;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_FETCH;
    else      state_reg <= state_next;
  end

  // Sticky trap flag, set on the edge that enters TRAP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         trap_reg <= 1'b0;
    else if (state_next == S_TRAP)    trap_reg <= 1'b1;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        instret_reg <= '0;
    else if (retire) instret_reg <= instret_reg + CNT_WIDTH'(1);
  end

  assign state   = state_reg;
  assign trap    = trap_reg;
  assign instret = instret_reg;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM that sequences a multi-cycle RV32I-subset datapath.
- The datapath shares one ALU and one unified instruction/data memory across several cycles per instruction.
- The FSM drives every mux select, write enable and the memory request.
- It decodes add/sub/and/or/slt, addi/andi/ori/slti, lw, sw, beq and bne.
- It keeps a retired-instruction counter and traps on any unsupported encoding.

Parameters:
CNT_WIDTH, 32, width of the instret counter.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
op  in  7  instr[6:0], valid from DECODE onward
funct3  in  3  instr[14:12]
funct7_5  in  1  instr[30]
zero  in  1  ALU result_eq_zero
mem_ready  in  1  memory accepts/completes current request this cycle
mem_req  out  1  memory access request
mem_we  out  1  write qualifier for mem_req
adr_src  out  1  0=PC, 1=ALUOut register
ir_write  out  1  latch instruction and old PC
pc_write  out  1  load PC from result mux
reg_write  out  1  register file write enable
alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1 register
alu_src_b  out  2  00=rs2 register, 01=imm, 10=constant 4
alu_ctrl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
result_src  out  2  00=ALUOut register, 01=data register, 10=ALU result
imm_src  out  2  00 I, 01 S, 10 B
trap  out  1  illegal instruction seen, core halted
state  out  4  current state encoding, debug
instret  out  CNT_WIDTH  retired instruction count

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, TRAP=15.
- Reset (rst=0): state forced to FETCH immediately; instret=0; trap=0.
  - While rst=0, all outputs are 0, including mem_req. This overrides the FETCH decode.
  - Reset applied mid-instruction abandons that instruction with no write.
- Any output not listed for a state is 0 in that state.
- FETCH: mem_req=1, adr_src=0.
  - Stays in FETCH while mem_ready=0.
  - On mem_ready=1, in the same cycle: ir_write=1, pc_write=1, alu_src_a=00, alu_src_b=10, alu_ctrl=add, result_src=10. Next state is DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_ctrl=add, imm_src=10 (precomputes the branch target into ALUOut).
  - op 0000011 with funct3=010, or op 0100011 with funct3=010 -> MEMADR.
  - op 0110011 with a legal funct -> EXEC_R.
  - op 0010011 with a legal funct3 -> EXEC_I.
  - op 1100011 with funct3 000 or 001 -> BRANCH.
  - Anything else -> TRAP.
- Legal funct values:
  - R-type: funct3 000 (funct7_5 selects add=0 / sub=1), 111 and, 110 or, 010 slt.
  - I-type: funct3 000, 111, 110, 010. funct7_5 is ignored for I-type.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_ctrl=add. imm_src=00 for lw, 01 for sw. Next state: lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, adr_src=1. Waits for mem_ready, then -> MEMWB.
- MEMWB: result_src=01, reg_write=1. Next state FETCH.
- MEMWR: mem_req=1, mem_we=1, adr_src=1. Waits for mem_ready, then -> FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_ctrl from funct. Next state ALUWB.
- EXEC_I: alu_src_a=10, alu_src_b=01, imm_src=00, alu_ctrl from funct3. Next state ALUWB.
- ALUWB: result_src=00, reg_write=1. Next state FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_ctrl=sub, result_src=00.
  - pc_write = zero XOR funct3[0] (beq taken when zero=1, bne taken when zero=0).
  - Next state FETCH.
- TRAP: trap=1, all other outputs 0. Absorbing; only reset exits.
- Handshake rules:
  - While waiting for mem_ready, mem_req, mem_we and adr_src hold stable.
  - mem_ready is ignored in states without mem_req.
  - No request is dropped: mem_req stays high until mem_ready is sampled high.
- Latency: R/I-type 4 cycles, lw 5, sw 4, branch 3, each plus memory wait cycles.
- instret increments by 1 on the clock edge leaving MEMWB, MEMWR (with mem_ready=1), ALUWB or BRANCH.
  - Wraps modulo 2^CNT_WIDTH.
  - Never increments for a trapped instruction.
- Next-state and outputs are a pure function of state and inputs; the only registers are state, instret and trap.

Test Plan:
- Reset: hold rst=0, then release with mem_ready=0 -> state=0 and mem_req=1 held across 5 stall cycles; instret=0.
- addi (op=0010011, funct3=000), mem_ready=1 -> state sequence 0,1,7,8,0; reg_write=1 only in state 8; instret goes 0->1 after 4 cycles.
- sub (op=0110011, f3=000, f7_5=1) then slt (f3=010) -> alu_ctrl=001 then 101 in EXEC_R.
- lw with mem_ready low for 3 cycles in MEMRD -> adr_src=1 stable; 8 cycles total; result_src=01 with reg_write=1 in MEMWB.
- bne with zero=1 -> pc_write=0 in BRANCH; with zero=0 -> pc_write=1. beq is the inverse. Both cases take 3 cycles.
- op=1111111 -> TRAP; trap=1 persists for 20 cycles with mem_req=0; instret unchanged. Async reset asserted mid-MEMWR -> immediate return to FETCH, outputs 0.
